// File: rtl/extract_field_stage.sv
// Key-field extraction stage: per-type rule lookup on start slices, 2-cycle head/meta pass-through.
// Optional start/miss counters are built when EXTRACT_STATS_EN is defined.
module extract_field_stage #(
  parameter int unsigned HEAD_WIDTH       = 512,
  parameter int unsigned META_WIDTH       = 512,
  parameter int unsigned TAG_WIDTH        = 8,
  parameter int unsigned KEY_FIELD_WIDTH  = 16,
  parameter int unsigned KEY_FIELD_NUM    = 8,
  parameter int unsigned OFF_WIDTH        = 5,
  parameter int unsigned HEAD_SHIFT_WIDTH = 5,
  parameter int unsigned META_CANDI_NUM   = 8,
  parameter int unsigned REP_OFFSET_WIDTH = 3,
  parameter int unsigned RULE_NUM         = 16,
  parameter int unsigned RULE_IDX_WIDTH   = 4,
  localparam int unsigned RULE_W = 2 + HEAD_SHIFT_WIDTH + KEY_FIELD_NUM*(1+OFF_WIDTH)
                                   + META_CANDI_NUM*(2+REP_OFFSET_WIDTH)
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst,
  input  logic [HEAD_WIDTH+TAG_WIDTH-1:0]            i_head,
  input  logic [META_WIDTH+TAG_WIDTH-1:0]            i_meta,
  input  logic [RULE_IDX_WIDTH-1:0]                  i_type,
  input  logic                                       i_rule_wr,
  input  logic [RULE_IDX_WIDTH-1:0]                  i_rule_addr,
  input  logic [RULE_W-1:0]                          i_rule_data,
  output logic [HEAD_WIDTH+TAG_WIDTH-1:0]            o_head,
  output logic [META_WIDTH+TAG_WIDTH-1:0]            o_meta,
  output logic [HEAD_SHIFT_WIDTH-1:0]                o_headShift,
  output logic                                       o_metaShift,
  output logic [KEY_FIELD_NUM*KEY_FIELD_WIDTH-1:0]   o_extField,
  output logic [META_CANDI_NUM*REP_OFFSET_WIDTH-1:0] o_replaceOffset,
  output logic [META_CANDI_NUM-1:0]                  o_replaceOffset_v,
  output logic [META_CANDI_NUM-1:0]                  o_replaceOffset_carry,
  output logic [31:0]                                o_pkt_cnt,
  output logic [31:0]                                o_miss_cnt
);

  localparam int unsigned HW_T     = HEAD_WIDTH + TAG_WIDTH;
  localparam int unsigned MW_T     = META_WIDTH + TAG_WIDTH;
  localparam int unsigned FLD_W    = 1 + OFF_WIDTH;
  localparam int unsigned CAND_W   = 2 + REP_OFFSET_WIDTH;
  localparam int unsigned WORDS    = HEAD_WIDTH / KEY_FIELD_WIDTH;
  localparam int unsigned FLD_MSB  = RULE_W - 3 - HEAD_SHIFT_WIDTH;
  localparam int unsigned CAND_MSB = META_CANDI_NUM*CAND_W - 1;

  logic [RULE_W-1:0] rule_tbl [RULE_NUM];
  logic [HW_T-1:0]   head1;
  logic [MW_T-1:0]   meta1;
  logic [RULE_W-1:0] rule1;
  logic              start1;
  logic              start_acc_c;
  logic              rule_valid_c;

  logic [KEY_FIELD_NUM*KEY_FIELD_WIDTH-1:0]   ext_c;
  logic [META_CANDI_NUM*REP_OFFSET_WIDTH-1:0] rep_c;
  logic [META_CANDI_NUM-1:0]                  rep_v_c;
  logic [META_CANDI_NUM-1:0]                  rep_carry_c;

  assign start_acc_c  = i_head[HEAD_WIDTH] & i_head[HEAD_WIDTH+1];
  assign rule_valid_c = rule1[RULE_W-1];

  // Rule table; a same-cycle lookup sees the pre-write entry.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(RULE_NUM); i++) rule_tbl[i] <= '0;
    end else if (i_rule_wr) begin
      rule_tbl[i_rule_addr] <= i_rule_data;
    end
  end

  // Stage 1: slice capture and rule lookup on accepted start slices.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head1  <= '0;
      meta1  <= '0;
      rule1  <= '0;
      start1 <= 1'b0;
    end else begin
      head1  <= i_head;
      meta1  <= i_meta;
      start1 <= start_acc_c;
      if (start_acc_c) rule1 <= rule_tbl[i_type];
    end
  end

  // Field extraction: offsets past the last slice word match nothing and yield 0.
  for (genvar k = 0; k < int'(KEY_FIELD_NUM); k++) begin : g_fld
    logic                       fld_v_c;
    logic [OFF_WIDTH-1:0]       fld_off_c;
    logic [KEY_FIELD_WIDTH-1:0] fld_c;
    assign fld_v_c   = rule1[FLD_MSB - k*FLD_W];
    assign fld_off_c = rule1[FLD_MSB - 1 - k*FLD_W -: OFF_WIDTH];
    always_comb begin
      fld_c = '0;
      for (int w = 0; w < int'(WORDS); w++) begin
        if (fld_v_c && (32'(fld_off_c) == 32'(w)))
          fld_c = head1[HEAD_WIDTH-1-w*KEY_FIELD_WIDTH -: KEY_FIELD_WIDTH];
      end
    end
    assign ext_c[k*KEY_FIELD_WIDTH +: KEY_FIELD_WIDTH] = fld_c;
  end

  for (genvar c = 0; c < int'(META_CANDI_NUM); c++) begin : g_cand
    assign rep_v_c[c]     = rule1[CAND_MSB - c*CAND_W];
    assign rep_carry_c[c] = rule1[CAND_MSB - 1 - c*CAND_W];
    assign rep_c[c*REP_OFFSET_WIDTH +: REP_OFFSET_WIDTH] =
      rule1[CAND_MSB - 2 - c*CAND_W -: REP_OFFSET_WIDTH];
  end

  // Stage 2: outputs align with the start slice on o_head and hold until the next one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_head                <= '0;
      o_meta                <= '0;
      o_headShift           <= '0;
      o_metaShift           <= 1'b0;
      o_extField            <= '0;
      o_replaceOffset       <= '0;
      o_replaceOffset_v     <= '0;
      o_replaceOffset_carry <= '0;
    end else begin
      o_head <= head1;
      o_meta <= meta1;
      if (start1) begin
        if (rule_valid_c) begin
          o_headShift           <= rule1[RULE_W-2 -: HEAD_SHIFT_WIDTH];
          o_metaShift           <= rule1[RULE_W-2-HEAD_SHIFT_WIDTH];
          o_extField            <= ext_c;
          o_replaceOffset       <= rep_c;
          o_replaceOffset_v     <= rep_v_c;
          o_replaceOffset_carry <= rep_carry_c;
        end else begin
          o_headShift           <= '0;
          o_metaShift           <= 1'b0;
          o_extField            <= '0;
          o_replaceOffset       <= '0;
          o_replaceOffset_v     <= '0;
          o_replaceOffset_carry <= '0;
        end
      end
    end
  end

`ifdef EXTRACT_STATS_EN
  // Counters advance with the outputs so they match the packet shown on o_head.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_pkt_cnt  <= '0;
      o_miss_cnt <= '0;
    end else if (start1) begin
      o_pkt_cnt <= o_pkt_cnt + 32'd1;
      if (!rule_valid_c) o_miss_cnt <= o_miss_cnt + 32'd1;
    end
  end
`else
  assign o_pkt_cnt  = '0;
  assign o_miss_cnt = '0;
`endif

endmodule

// File: doc/extract_field_stage.md
Name: extract_field_stage

Overview:
- Pipelined key-field extraction stage sitting directly upstream of the head-shift/meta-replace stage.
- On each packet's start head slice it looks up a per-type rule, extracts KEY_FIELD_NUM fields from that slice, and emits head shift, meta shift and meta replace offsets.
- Head and meta pass through with fixed 2-cycle latency, so every control output is valid in the same cycle as the start slice it belongs to.

Parameters:
- HEAD_WIDTH, 512, head slice data width (bits).
- META_WIDTH, 512, meta slice data width (bits).
- TAG_WIDTH, 8, tag bits above data. Bit 0 = valid, bit 1 = start, bit 2 = tail, bit 3 = shift.
- KEY_FIELD_WIDTH, 16, extracted field width; also the offset granularity.
- KEY_FIELD_NUM, 8, number of extracted fields.
- OFF_WIDTH, 5, field offset width, in KEY_FIELD_WIDTH units from slice MSB.
- HEAD_SHIFT_WIDTH, 5, head shift amount width.
- META_CANDI_NUM, 8, number of meta replace candidates.
- REP_OFFSET_WIDTH, 3, replace-offset width (selects an extracted field).
- RULE_NUM, 16, rule table depth.
- RULE_IDX_WIDTH, 4, log2(RULE_NUM).

Ports:
- i_clk, in, 1, clock.
- i_rst, in, 1, asynchronous active-high reset.
- i_head, in, HEAD_WIDTH+TAG_WIDTH, tagged head slice.
- i_meta, in, META_WIDTH+TAG_WIDTH, tagged meta slice, aligned with i_head.
- i_type, in, RULE_IDX_WIDTH, rule index; sampled only on a start slice.
- i_rule_wr, in, 1, rule table write strobe.
- i_rule_addr, in, RULE_IDX_WIDTH, rule write address.
- i_rule_data, in, RULE_W, rule entry (layout below).
- o_head, out, HEAD_WIDTH+TAG_WIDTH, i_head delayed 2 cycles.
- o_meta, out, META_WIDTH+TAG_WIDTH, i_meta delayed 2 cycles.
- o_headShift, out, HEAD_SHIFT_WIDTH, head shift for the current packet.
- o_metaShift, out, 1, meta shift request.
- o_extField, out, KEY_FIELD_NUM*KEY_FIELD_WIDTH, extracted fields; field 0 in the LSBs.
- o_replaceOffset, out, META_CANDI_NUM*REP_OFFSET_WIDTH, per-candidate field select.
- o_replaceOffset_v, out, META_CANDI_NUM, per-candidate replace enable.
- o_replaceOffset_carry, out, META_CANDI_NUM, 1 = apply the replace on the second meta slice.
- o_pkt_cnt, out, 32, start-slice count (optional feature).
- o_miss_cnt, out, 32, invalid-rule count (optional feature).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Rule entry layout, MSB to LSB:
  - valid (1)
  - headShift (HEAD_SHIFT_WIDTH)
  - metaShift (1)
  - KEY_FIELD_NUM x {fld_v (1), fld_off (OFF_WIDTH)}, field 0 first
  - META_CANDI_NUM x {rep_v (1), rep_carry (1), rep_off (REP_OFFSET_WIDTH)}, candidate 0 first
  - RULE_W = 2 + HEAD_SHIFT_WIDTH + KEY_FIELD_NUM*(1+OFF_WIDTH) + META_CANDI_NUM*(2+REP_OFFSET_WIDTH).
- Reset:
  - All outputs, pipeline registers and counters go to 0.
  - All rule entries go to 0 (invalid).
- Rule table write:
  - When i_rule_wr = 1, the table entry at i_rule_addr takes i_rule_data at the clock edge.
  - Write and lookup of the same entry in the same cycle: the lookup returns the OLD entry.
- Stage 1 (cycle after the start slice arrives):
  - On start slice (i_head start bit AND valid bit), register rule[i_type] and register the head data.
  - Head and meta advance unconditionally every cycle, including non-valid slices.
- Stage 2 (cycle after stage 1):
  - For each field k: o_extField[k] = head bits [HEAD_WIDTH-1-fld_off*KEY_FIELD_WIDTH -: KEY_FIELD_WIDTH] if fld_v = 1, else 0.
  - fld_off values beyond the slice (off >= HEAD_WIDTH/KEY_FIELD_WIDTH) yield 0.
  - o_headShift, o_metaShift and o_replaceOffset* are loaded from the registered rule.
  - If rule valid = 0: all of them are 0 and o_extField is 0.
- Alignment: control outputs update in exactly the cycle o_head carries the start slice, then hold until the next start slice.
- Back-to-back start slices on consecutive cycles: each packet gets its own rule; no stalls, no bubbles.
- A start slice with valid bit = 0 is ignored: no lookup, outputs hold.
- Reset asserted mid-packet: the pipeline is flushed; slices in flight are dropped (o_head tags go to 0).

Optional Feature:
- Macro: EXTRACT_STATS_EN.
- Defined:
  - o_pkt_cnt increments once per accepted start slice.
  - o_miss_cnt increments when the looked-up rule has valid = 0.
  - Both counters wrap at 2^32 - 1 -> 0 and are cleared only by reset.
- Undefined: both ports are tied to 0 and no counter logic is generated.

Test Plan:
- Reset: assert i_rst mid-stream -> every output is 0 in the same cycle; all rules read invalid afterwards.
- Basic extraction:
  - Stimulus: rule 3 = {valid=1, headShift=7, metaShift=1, field0 v=1 off=6, field1 v=1 off=0}; start slice with type=3 and slice word 6 = 0x0800.
  - Required response 2 cycles later: o_extField[0] = 0x0800, o_extField[1] = top 16 bits of the slice, o_headShift = 7, o_metaShift = 1, start tag on o_head.
- Invalid rule: type=5 left unprogrammed -> o_extField, o_headShift and o_replaceOffset_v all 0; with EXTRACT_STATS_EN, o_miss_cnt = 1.
- Write/lookup collision: rewrite rule 3 with headShift=2 in the same cycle as a start slice with type=3 -> that packet sees 7; the next packet sees 2.
- Back-to-back packets: start slices with type=1, then type=2 on consecutive cycles -> outputs switch rule on consecutive cycles, each aligned with its start slice on o_head.
- Replace fields:
  - Stimulus: rule with candidate 2 = {rep_v=1, rep_carry=1, rep_off=4}.
  - Required response: o_replaceOffset[2] = 4, o_replaceOffset_v[2] = 1, o_replaceOffset_carry[2] = 1, all other candidates 0.
